// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Hazard and pipeline-control unit for the 5-stage MIPS core. It detects
//   load-use hazards, taken branches/jumps and data-memory wait states. From
//   these it produces the PC / IF/ID / ID/EX enables and flushes, plus the
//   freeze for the back half of the pipe. Control outputs are combinational
//   from the registered state and the current inputs, so a hazard is answered
//   in the same cycle it is seen.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   i_id_rs/i_id_rt    source register fields of the instruction in ID
//   i_id_uses_rt       ID instruction reads rt as a source
//   i_ex_mem_read      EX instruction is a load; i_ex_rt is its destination
//   i_ex_branch_taken  branch resolved taken in EX
//   i_id_jump          jump/jal/jr decoded in ID
//   i_mem_req          MEM stage has an active data-memory access
//   i_mem_ready        data memory completes the access this cycle
//   o_pc_write         PC load enable
//   o_if_id_write      IF/ID load enable
//   o_if_id_flush      IF/ID clear
//   o_id_ex_flush      ID/EX bubble insert (drives the ID/EX i_flush)
//   o_pipe_hold        freeze ID/EX, EX/MEM and MEM/WB
//   o_mem_timeout      sticky flag: memory wait lasted MEM_TIMEOUT cycles
//   o_stall_cycles     saturating count of cycles with o_pc_write low
//   o_flush_count      saturating count of taken-branch flushes
module hazard_ctrl_unit #(
  parameter int REG_W        = 5,
  parameter int LOAD_BUBBLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rt,
  input  logic             i_ex_branch_taken,
  input  logic             i_id_jump,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_pipe_hold,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  localparam int             TW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]  TO_MAX   = TW'(MEM_TIMEOUT);
  localparam logic [2:0]     BUB_INIT = 3'(LOAD_BUBBLES - 1);

  typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TW-1:0] sat_inc_to(input logic [TW-1:0] v);
    return (v == TO_MAX) ? v : v + TW'(1);
  endfunction

  state_t          state_q, state_nxt, ret_q, ret_nxt, eff;
  logic [2:0]      bub_q, bub_nxt;
  logic [TW-1:0]   to_q, to_inc;
  logic            timeout_q, timeout_now;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic memwait, loaduse, branch_hit;
  logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_flush_c, hold_c;

  assign memwait = i_mem_req & ~i_mem_ready;
  assign loaduse = i_ex_mem_read & (i_ex_rt != '0) &
                   ((i_ex_rt == i_id_rs) | (i_id_uses_rt & (i_ex_rt == i_id_rt)));

  assign to_inc      = sat_inc_to(to_q);
  assign timeout_now = memwait & (to_inc == TO_MAX);

  // Next-state and control decode. In MEM_WAIT, once memory is ready the
  // unit behaves as the state it interrupted (ret_q) for this same cycle.
  always_comb begin
    state_nxt     = state_q;
    ret_nxt       = ret_q;
    bub_nxt       = bub_q;
    branch_hit    = 1'b0;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    hold_c        = 1'b0;
    eff           = (state_q == MEM_WAIT) ? ret_q : state_q;

    if (memwait) begin
      // Whole pipe frozen; bubble count is paused until memory answers.
      hold_c        = 1'b1;
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      state_nxt     = MEM_WAIT;
      ret_nxt       = eff;
    end else if (i_ex_branch_taken) begin
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      branch_hit    = 1'b1;
      bub_nxt       = 3'd0;
      state_nxt     = RUN;
    end else if ((eff == RUN) && i_id_jump && !loaduse) begin
      // A coincident load-use wins over the jump: ID is held, so the
      // jump is seen again next cycle.
      if_id_flush_c = 1'b1;
      state_nxt     = RUN;
    end else if (((eff == RUN) && loaduse) || (eff == STALL)) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      id_ex_flush_c = 1'b1;
      if (eff == STALL) begin
        bub_nxt   = (bub_q == 3'd0) ? 3'd0 : bub_q - 3'd1;
        state_nxt = (bub_q <= 3'd1) ? RUN : STALL;
      end else if (LOAD_BUBBLES > 1) begin
        bub_nxt   = BUB_INIT;
        state_nxt = STALL;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      state_nxt = RUN;
    end
  end

  // Reset forces a safe flushed/not-advancing pipe regardless of state.
  assign o_pc_write     = reset ? 1'b0 : pc_write_c;
  assign o_if_id_write  = reset ? 1'b0 : if_id_write_c;
  assign o_if_id_flush  = reset ? 1'b1 : if_id_flush_c;
  assign o_id_ex_flush  = reset ? 1'b1 : id_ex_flush_c;
  assign o_pipe_hold    = reset ? 1'b0 : hold_c;
  assign o_mem_timeout  = ~reset & (timeout_q | timeout_now);
  assign o_stall_cycles = stall_q;
  assign o_flush_count  = flush_q;

  // State, counters and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      ret_q     <= RUN;
      bub_q     <= 3'd0;
      to_q      <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_nxt;
      ret_q     <= ret_nxt;
      bub_q     <= bub_nxt;
      to_q      <= memwait ? to_inc : '0;
      timeout_q <= timeout_q | timeout_now;
      if (!pc_write_c) stall_q <= sat_inc_cnt(stall_q);
      if (branch_hit)  flush_q <= sat_inc_cnt(flush_q);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit. Three instances share one set of inputs and
// differ only in LOAD_BUBBLES (1, 2, 3); each scenario checks the instance
// it is aimed at. Control outputs are compared as the 5-bit vector
// {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold}.
module tb_hazard_ctrl_unit;

  localparam logic [4:0] C_RESET  = 5'b00110;
  localparam logic [4:0] C_NORMAL = 5'b11000;
  localparam logic [4:0] C_BUBBLE = 5'b00010;
  localparam logic [4:0] C_BRANCH = 5'b11110;
  localparam logic [4:0] C_JUMP   = 5'b11100;
  localparam logic [4:0] C_HOLD   = 5'b00001;

  logic       clk, reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, br, jmp, mem_req, mem_ready;

  wire [4:0]  ctl1, ctl2, ctl3;
  wire        to1, to2, to3;
  wire [15:0] st1, st2, st3, fc1, fc2, fc3;

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl_unit #(.REG_W(5), .LOAD_BUBBLES(1), .MEM_TIMEOUT(4), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_branch_taken(br), .i_id_jump(jmp),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_write(ctl1[4]), .o_if_id_write(ctl1[3]), .o_if_id_flush(ctl1[2]),
    .o_id_ex_flush(ctl1[1]), .o_pipe_hold(ctl1[0]), .o_mem_timeout(to1),
    .o_stall_cycles(st1), .o_flush_count(fc1));

  hazard_ctrl_unit #(.REG_W(5), .LOAD_BUBBLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_branch_taken(br), .i_id_jump(jmp),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_write(ctl2[4]), .o_if_id_write(ctl2[3]), .o_if_id_flush(ctl2[2]),
    .o_id_ex_flush(ctl2[1]), .o_pipe_hold(ctl2[0]), .o_mem_timeout(to2),
    .o_stall_cycles(st2), .o_flush_count(fc2));

  hazard_ctrl_unit #(.REG_W(5), .LOAD_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_ex_branch_taken(br), .i_id_jump(jmp),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_write(ctl3[4]), .o_if_id_write(ctl3[3]), .o_if_id_flush(ctl3[2]),
    .o_id_ex_flush(ctl3[1]), .o_pipe_hold(ctl3[0]), .o_mem_timeout(to3),
    .o_stall_cycles(st3), .o_flush_count(fc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read on
  // the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; ex_mem_read = 0;
    br = 0; jmp = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #3;
    vectors++; if (ctl1 !== C_RESET) begin miscompares++; $display("FAIL reset_ctl1 got %b want %b", ctl1, C_RESET); end
    vectors++; if (ctl3 !== C_RESET) begin miscompares++; $display("FAIL reset_ctl3 got %b want %b", ctl3, C_RESET); end
    vectors++; if ({to1, st1, fc1} !== 33'd0) begin miscompares++; $display("FAIL reset_cnt1 got to=%b st=%0d fc=%0d want 0", to1, st1, fc1); end
    tick();
    tick();
    reset = 1'b0;
    settle();
    vectors++; if (ctl1 !== C_NORMAL) begin miscompares++; $display("FAIL release_ctl1 got %b want %b", ctl1, C_NORMAL); end
  endtask

  task automatic test_load_use_lb1();
    pulse_reset();
    ex_mem_read = 1; ex_rt = 8; id_rs = 8;
    settle();
    vectors++; if (ctl1 !== C_BUBBLE) begin miscompares++; $display("FAIL lu1_bubble got %b want %b", ctl1, C_BUBBLE); end
    tick();
    ex_mem_read = 0;
    settle();
    vectors++; if (ctl1 !== C_NORMAL) begin miscompares++; $display("FAIL lu1_after got %b want %b", ctl1, C_NORMAL); end
    vectors++; if (st1 !== 16'd1) begin miscompares++; $display("FAIL lu1_stalls got %0d want 1", st1); end
    tick();
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    settle();
    vectors++; if (ctl1 !== C_NORMAL) begin miscompares++; $display("FAIL lu1_r0 got %b want %b", ctl1, C_NORMAL); end
    tick();
    ex_mem_read = 0;
    settle();
    vectors++; if (st1 !== 16'd1) begin miscompares++; $display("FAIL lu1_r0_stalls got %0d want 1", st1); end
  endtask

  task automatic test_load_use_lb3();
    pulse_reset();
    ex_mem_read = 1; ex_rt = 9; id_rt = 9; id_rs = 3; id_uses_rt = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      vectors++; if (ctl3 !== C_BUBBLE) begin miscompares++; $display("FAIL lu3_bubble%0d got %b want %b", i, ctl3, C_BUBBLE); end
      tick();
      ex_mem_read = 0;
    end
    settle();
    vectors++; if (ctl3 !== C_NORMAL) begin miscompares++; $display("FAIL lu3_after got %b want %b", ctl3, C_NORMAL); end
    vectors++; if (st3 !== 16'd3) begin miscompares++; $display("FAIL lu3_stalls got %0d want 3", st3); end
    tick();
    ex_mem_read = 1; id_uses_rt = 0;
    settle();
    vectors++; if (ctl3 !== C_NORMAL) begin miscompares++; $display("FAIL lu3_no_rt got %b want %b", ctl3, C_NORMAL); end
    tick();
    ex_mem_read = 0;
    settle();
    vectors++; if (st3 !== 16'd3) begin miscompares++; $display("FAIL lu3_no_rt_stalls got %0d want 3", st3); end
  endtask

  task automatic test_branch_loaduse();
    pulse_reset();
    ex_mem_read = 1; ex_rt = 8; id_rs = 8; br = 1;
    settle();
    vectors++; if (ctl3 !== C_BRANCH) begin miscompares++; $display("FAIL br_lu_ctl3 got %b want %b", ctl3, C_BRANCH); end
    vectors++; if (ctl1 !== C_BRANCH) begin miscompares++; $display("FAIL br_lu_ctl1 got %b want %b", ctl1, C_BRANCH); end
    tick();
    clear_inputs();
    settle();
    vectors++; if (ctl3 !== C_NORMAL) begin miscompares++; $display("FAIL br_lu_after got %b want %b", ctl3, C_NORMAL); end
    vectors++; if (fc3 !== 16'd1) begin miscompares++; $display("FAIL br_lu_flushes got %0d want 1", fc3); end
    vectors++; if (st3 !== 16'd0) begin miscompares++; $display("FAIL br_lu_stalls got %0d want 0", st3); end
  endtask

  task automatic test_jump();
    pulse_reset();
    jmp = 1;
    settle();
    vectors++; if (ctl1 !== C_JUMP) begin miscompares++; $display("FAIL jump_ctl got %b want %b", ctl1, C_JUMP); end
    tick();
    ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    settle();
    vectors++; if (ctl1 !== C_BUBBLE) begin miscompares++; $display("FAIL jump_lu_ctl got %b want %b", ctl1, C_BUBBLE); end
    tick();
    ex_mem_read = 0;
    settle();
    vectors++; if (ctl1 !== C_JUMP) begin miscompares++; $display("FAIL jump_reseen got %b want %b", ctl1, C_JUMP); end
    tick();
    clear_inputs();
  endtask

  task automatic test_mem_timeout();
    pulse_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      settle();
      vectors++; if (ctl1 !== C_HOLD) begin miscompares++; $display("FAIL mw_hold%0d got %b want %b", i, ctl1, C_HOLD); end
      vectors++; if (to1 !== (i >= 4)) begin miscompares++; $display("FAIL mw_timeout%0d got %b want %b", i, to1, (i >= 4)); end
      tick();
    end
    mem_ready = 1;
    settle();
    vectors++; if (ctl1 !== C_NORMAL) begin miscompares++; $display("FAIL mw_ready got %b want %b", ctl1, C_NORMAL); end
    vectors++; if (to1 !== 1'b1) begin miscompares++; $display("FAIL mw_sticky got %b want 1", to1); end
    tick();
    clear_inputs();
    settle();
    vectors++; if (to1 !== 1'b1) begin miscompares++; $display("FAIL mw_sticky2 got %b want 1", to1); end
    vectors++; if (st1 !== 16'd6) begin miscompares++; $display("FAIL mw_stalls got %0d want 6", st1); end
  endtask

  task automatic test_memwait_in_stall();
    pulse_reset();
    ex_mem_read = 1; ex_rt = 7; id_rs = 7;
    settle();
    vectors++; if (ctl2 !== C_BUBBLE) begin miscompares++; $display("FAIL ms_bubble1 got %b want %b", ctl2, C_BUBBLE); end
    tick();
    ex_mem_read = 0; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      vectors++; if (ctl2 !== C_HOLD) begin miscompares++; $display("FAIL ms_hold%0d got %b want %b", i, ctl2, C_HOLD); end
      tick();
    end
    mem_ready = 1;
    settle();
    vectors++; if (ctl2 !== C_BUBBLE) begin miscompares++; $display("FAIL ms_bubble2 got %b want %b", ctl2, C_BUBBLE); end
    tick();
    clear_inputs();
    settle();
    vectors++; if (ctl2 !== C_NORMAL) begin miscompares++; $display("FAIL ms_after got %b want %b", ctl2, C_NORMAL); end
    vectors++; if (st2 !== 16'd5) begin miscompares++; $display("FAIL ms_stalls got %0d want 5", st2); end
    vectors++; if (to2 !== 1'b0) begin miscompares++; $display("FAIL ms_timeout got %b want 0", to2); end
  endtask

  task automatic test_reset_mid_stall();
    pulse_reset();
    ex_mem_read = 1; ex_rt = 4; id_rs = 4;
    settle();
    vectors++; if (ctl3 !== C_BUBBLE) begin miscompares++; $display("FAIL rms_bubble1 got %b want %b", ctl3, C_BUBBLE); end
    tick();
    ex_mem_read = 0;
    settle();
    vectors++; if (ctl3 !== C_BUBBLE) begin miscompares++; $display("FAIL rms_bubble2 got %b want %b", ctl3, C_BUBBLE); end
    reset = 1'b1;
    #1;
    vectors++; if (ctl3 !== C_RESET) begin miscompares++; $display("FAIL rms_forced got %b want %b", ctl3, C_RESET); end
    vectors++; if (st3 !== 16'd0) begin miscompares++; $display("FAIL rms_stalls_clr got %0d want 0", st3); end
    tick();
    reset = 1'b0;
    settle();
    vectors++; if (ctl3 !== C_NORMAL) begin miscompares++; $display("FAIL rms_release got %b want %b", ctl3, C_NORMAL); end
    tick();
    settle();
    vectors++; if (ctl3 !== C_NORMAL) begin miscompares++; $display("FAIL rms_run got %b want %b", ctl3, C_NORMAL); end
    vectors++; if ({st3, fc3} !== 32'd0) begin miscompares++; $display("FAIL rms_counters got st=%0d fc=%0d want 0", st3, fc3); end
  endtask

  initial begin
    test_reset();
    test_load_use_lb1();
    test_load_use_lb3();
    test_branch_loaduse();
    test_jump();
    test_mem_timeout();
    test_memwait_in_stall();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
